// File: rtl/encdec_apb_pkg.sv
// Shared register map, transfer states and sequence order for the EncDec APB initiator.
package encdec_apb_pkg;

    localparam logic [1:0] REG_CTRL     = 2'b00;
    localparam logic [1:0] REG_DATA_IN  = 2'b01;
    localparam logic [1:0] REG_CW_WIDTH = 2'b10;
    localparam logic [1:0] REG_NOISE    = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } xfer_state_e;

    // CTRL goes last so the operation launches on fully loaded operands.
    localparam logic [3:0][1:0] SEQ_ORDER = {REG_CTRL, REG_NOISE, REG_CW_WIDTH, REG_DATA_IN};
    localparam logic [1:0] SEQ_LAST = 2'd3;

endpackage

// File: rtl/encdec_apb_xfer.sv
// Two-phase APB transfer engine (SETUP, ACCESS) with optional ACCESS-phase
// timeout enabled by ENCDEC_APB_TIMEOUT_EN.
module encdec_apb_xfer
    import encdec_apb_pkg::*;
#(
    parameter int AW             = 20,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          start_write,
    input  logic [AW-1:0] start_addr,
    input  logic [DW-1:0] start_wdata,
    output logic          idle,
    output logic          complete,
    output logic          complete_err,
    output logic [DW-1:0] complete_rdata,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    input  logic [DW-1:0] prdata,
    input  logic          pready,
    input  logic          pslverr
);

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("encdec_apb_xfer: TIMEOUT_CYCLES must be at least 1");
    end

    xfer_state_e state;
    logic        expired;
    logic        load;

    assign idle = (state == IDLE);

`ifdef ENCDEC_APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign expired = (state == ACCESS) && !pready && (wait_cnt == LAST);
`else
    assign expired = 1'b0;
`endif

    assign complete       = (state == ACCESS) && (pready || expired);
    assign complete_err   = expired || pslverr;
    assign complete_rdata = expired ? '0 : prdata;
    assign load           = start && (idle || complete);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) begin
                        state <= SETUP;
                        psel  <= 1'b1;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    if (complete) begin
                        penable <= 1'b0;
                        if (load) begin
                            state <= SETUP;
                        end else begin
                            state <= IDLE;
                            psel  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
            // Address/data only change on a new transfer, so they hold while idle.
            if (load) begin
                pwrite <= start_write;
                paddr  <= start_addr;
                pwdata <= start_wdata;
            end
        end
    end

endmodule

// File: rtl/encdec_apb_master.sv
// APB initiator for the EncDec register block: single commands plus a four-write
// operand sequence. ENCDEC_APB_TIMEOUT_EN enables the ACCESS-phase timeout.
module encdec_apb_master
    import encdec_apb_pkg::*;
#(
    parameter int                         AMBA_ADDR_WIDTH = 20,
    parameter int                         AMBA_WORD       = 32,
    parameter logic [AMBA_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                         TIMEOUT_CYCLES  = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [1:0]                 cmd_reg,
    input  logic [AMBA_WORD-1:0]       cmd_wdata,
    output logic                       rsp_valid,
    output logic [AMBA_WORD-1:0]       rsp_rdata,
    output logic                       rsp_err,
    input  logic                       seq_start,
    input  logic [AMBA_WORD-1:0]       seq_ctrl,
    input  logic [AMBA_WORD-1:0]       seq_data_in,
    input  logic [AMBA_WORD-1:0]       seq_cw_width,
    input  logic [AMBA_WORD-1:0]       seq_noise,
    output logic                       seq_busy,
    output logic                       seq_done,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic [AMBA_WORD-1:0]       PRDATA,
    input  logic                       PREADY,
    input  logic                       PSLVERR
);

    if (BASE_ADDR[3:2] != 2'b00) begin : g_base_check
        $error("encdec_apb_master: BASE_ADDR[3:2] must be zero");
    end

    logic                       idle;
    logic                       complete;
    logic                       complete_err;
    logic [AMBA_WORD-1:0]       complete_rdata;
    logic                       take_seq;
    logic                       take_cmd;
    logic                       chain;
    logic                       start;
    logic                       start_write;
    logic [1:0]                 start_reg;
    logic [1:0]                 next_reg;
    logic [AMBA_WORD-1:0]       start_wdata;
    logic [AMBA_ADDR_WIDTH-1:0] start_addr;
    logic                       seq_active;
    logic                       cur_write;
    logic [1:0]                 seq_idx;
    logic [AMBA_WORD-1:0]       ops [4];

    // A sequence request wins over a command presented in the same cycle.
    assign cmd_ready = PRESETn && idle && !seq_start;
    assign take_seq  = PRESETn && idle && seq_start;
    assign take_cmd  = cmd_valid && cmd_ready;
    assign chain     = complete && seq_active && !complete_err && (seq_idx != SEQ_LAST);
    assign start     = take_seq || take_cmd || chain;
    assign seq_busy  = seq_active;
    assign next_reg  = SEQ_ORDER[seq_idx + 2'd1];

    always_comb begin
        start_write = 1'b1;
        start_reg   = SEQ_ORDER[0];
        start_wdata = seq_data_in;
        if (take_cmd) begin
            start_write = cmd_write;
            start_reg   = cmd_reg;
            start_wdata = cmd_wdata;
        end else if (chain) begin
            start_reg   = next_reg;
            start_wdata = ops[next_reg];
        end
    end

    assign start_addr = BASE_ADDR | AMBA_ADDR_WIDTH'({start_reg, 2'b00});

    always_ff @(posedge PCLK) begin
        if (take_seq) begin
            ops[REG_CTRL]     <= seq_ctrl;
            ops[REG_DATA_IN]  <= seq_data_in;
            ops[REG_CW_WIDTH] <= seq_cw_width;
            ops[REG_NOISE]    <= seq_noise;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            seq_active <= 1'b0;
            seq_idx    <= '0;
            cur_write  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            seq_done   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            seq_done  <= 1'b0;
            if (take_seq) begin
                seq_active <= 1'b1;
                seq_idx    <= '0;
            end
            if (take_cmd) begin
                cur_write <= cmd_write;
            end
            if (chain) begin
                seq_idx <= seq_idx + 2'd1;
            end else if (complete) begin
                rsp_err <= complete_err;
                if (seq_active) begin
                    seq_active <= 1'b0;
                    seq_done   <= 1'b1;
                    rsp_rdata  <= '0;
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= cur_write ? '0 : complete_rdata;
                end
            end
        end
    end

    encdec_apb_xfer #(
        .AW             (AMBA_ADDR_WIDTH),
        .DW             (AMBA_WORD),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_xfer (
        .clk            (PCLK),
        .rst_n          (PRESETn),
        .start          (start),
        .start_write    (start_write),
        .start_addr     (start_addr),
        .start_wdata    (start_wdata),
        .idle           (idle),
        .complete       (complete),
        .complete_err   (complete_err),
        .complete_rdata (complete_rdata),
        .psel           (PSEL),
        .penable        (PENABLE),
        .pwrite         (PWRITE),
        .paddr          (PADDR),
        .pwdata         (PWDATA),
        .prdata         (PRDATA),
        .pready         (PREADY),
        .pslverr        (PSLVERR)
    );

endmodule

// File: tb/tb_encdec_apb_master.sv
// Self-checking bench for encdec_apb_master: vector table, sequences, reset abort.
module tb_encdec_apb_master;
    import encdec_apb_pkg::*;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [1:0]    cmd_reg = 2'd0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          seq_start = 1'b0;
    logic [DW-1:0] seq_ctrl = '0;
    logic [DW-1:0] seq_data_in = '0;
    logic [DW-1:0] seq_cw_width = '0;
    logic [DW-1:0] seq_noise = '0;
    logic          seq_busy;
    logic          seq_done;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    encdec_apb_master #(
        .AMBA_ADDR_WIDTH (AW),
        .AMBA_WORD       (DW),
        .BASE_ADDR       ('0),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_reg      (cmd_reg),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .seq_start    (seq_start),
        .seq_ctrl     (seq_ctrl),
        .seq_data_in  (seq_data_in),
        .seq_cw_width (seq_cw_width),
        .seq_noise    (seq_noise),
        .seq_busy     (seq_busy),
        .seq_done     (seq_done),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PWRITE       (PWRITE),
        .PADDR        (PADDR),
        .PWDATA       (PWDATA),
        .PRDATA       (PRDATA),
        .PREADY       (PREADY),
        .PSLVERR      (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
    } xf_t;

    rsp_t rsp_q[$];
    logic seq_q[$];
    xf_t  xf_q[$];

    logic [DW-1:0] mem [4] = '{default: '0};
    int wait_cfg = 0;
    int err_at = -1;
    int nxfer = 0;
    int wcnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got event, want none", name);
    endtask

    function automatic logic [AW-1:0] addr_of(input logic [1:0] r);
        logic [AW-1:0] a;
        a = '0;
        a[3:2] = r;
        return a;
    endfunction

    task automatic push_xf(input logic [1:0] r, input logic wr, input logic [DW-1:0] d);
        xf_t e;
        e.addr = addr_of(r);
        e.wr = wr;
        e.wdata = d;
        xf_q.push_back(e);
    endtask

    task automatic push_rsp(input logic [DW-1:0] d, input logic err);
        rsp_t e;
        e.rdata = d;
        e.err = err;
        rsp_q.push_back(e);
    endtask

    // APB slave model plus transfer scoreboard.
    always @(negedge PCLK) begin : slave
        xf_t e;
        if (PSEL && PENABLE) begin
            PREADY = (wcnt >= wait_cfg);
            PRDATA = mem[PADDR[3:2]];
            PSLVERR = PREADY && (nxfer == err_at);
            wcnt++;
            if (PREADY) begin
                if (xf_q.size() == 0) begin
                    fail("xfer_unexpected");
                end else begin
                    e = xf_q.pop_front();
                    chk("xfer_addr", 64'(PADDR), 64'(e.addr));
                    chk("xfer_write", 64'(PWRITE), 64'(e.wr));
                    if (e.wr) chk("xfer_wdata", 64'(PWDATA), 64'(e.wdata));
                end
                if (PWRITE && !PSLVERR) mem[PADDR[3:2]] = PWDATA;
                nxfer++;
            end
        end else begin
            PREADY = 1'b0;
            PSLVERR = 1'b0;
            wcnt = 0;
        end
    end

    // Response scoreboard.
    always @(negedge PCLK) begin : monitor
        rsp_t r;
        logic s;
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                fail("rsp_unexpected");
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(r.err));
                chk("rsp_cmd_ready", 64'(cmd_ready), 64'd1);
            end
        end
        if (seq_done) begin
            if (seq_q.size() == 0) begin
                fail("seq_done_unexpected");
            end else begin
                s = seq_q.pop_front();
                chk("seq_err", 64'(rsp_err), 64'(s));
            end
        end
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge PCLK);
            lat++;
        end while (!rsp_valid && lat < 100);
        if (!rsp_valid) fail("rsp_timeout");
    endtask

    task automatic seq_run(output int n, output int busy_bad);
        n = 0;
        busy_bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge PCLK);
            if (!PSEL) break;
            n++;
            if (!seq_busy) busy_bad++;
        end
    endtask

    typedef struct {
        logic          wr;
        logic [1:0]    r;
        logic [DW-1:0] wdata;
        int            waits;
        logic          err;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vec [9];

    initial begin
        int lat;
        int n;
        int bad;
        vec[0] = '{1'b1, REG_DATA_IN,  32'hA5A5_0001, 0, 1'b0, 32'h0};
        vec[1] = '{1'b1, REG_NOISE,    32'h0000_0003, 0, 1'b0, 32'h0};
        vec[2] = '{1'b0, REG_NOISE,    32'h0,         3, 1'b0, 32'h0000_0003};
        vec[3] = '{1'b0, REG_DATA_IN,  32'h0,         0, 1'b0, 32'hA5A5_0001};
        vec[4] = '{1'b1, REG_CTRL,     32'hDEAD_BEEF, 1, 1'b1, 32'h0};
        vec[5] = '{1'b0, REG_CTRL,     32'h0,         0, 1'b0, 32'h0};
        vec[6] = '{1'b1, REG_CW_WIDTH, 32'h0000_0010, 2, 1'b0, 32'h0};
        vec[7] = '{1'b0, REG_CW_WIDTH, 32'h0,         0, 1'b0, 32'h0000_0010};
        vec[8] = '{1'b0, REG_DATA_IN,  32'h0,         1, 1'b1, 32'hA5A5_0001};

        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset_ctrl", 64'({cmd_ready, rsp_valid, rsp_err, seq_busy,
                               seq_done, PSEL, PENABLE, PWRITE}), 64'd0);
        chk("reset_paddr", 64'(PADDR), 64'd0);
        chk("reset_pwdata", 64'(PWDATA), 64'd0);
        chk("reset_rdata", 64'(rsp_rdata), 64'd0);
        step();
        PRESETn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            step();
            wait_cfg = vec[i].waits;
            err_at = vec[i].err ? 0 : -1;
            nxfer = 0;
            push_xf(vec[i].r, vec[i].wr, vec[i].wdata);
            push_rsp(vec[i].rdata, vec[i].err);
            cmd_valid = 1'b1;
            cmd_write = vec[i].wr;
            cmd_reg = vec[i].r;
            cmd_wdata = vec[i].wdata;
            n = 0;
            do begin
                @(negedge PCLK);
                n++;
            end while (!cmd_ready && n < 20);
            chk("cmd_accept", 64'(cmd_ready), 64'd1);
            step();
            cmd_valid = 1'b0;
            @(negedge PCLK);
            chk("setup_phase", 64'({PSEL, PENABLE}), 64'b10);
            chk("setup_paddr", 64'(PADDR), 64'(addr_of(vec[i].r)));
            wait_rsp(lat);
            chk("rsp_latency", 64'(lat), 64'(2 + vec[i].waits));
        end

        // Sequence with a competing command in the same cycle.
        step();
        wait_cfg = 0;
        err_at = -1;
        nxfer = 0;
        seq_start = 1'b1;
        seq_ctrl = 32'h1;
        seq_data_in = 32'h55;
        seq_cw_width = 32'h2;
        seq_noise = 32'h4;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_reg = REG_DATA_IN;
        push_xf(REG_DATA_IN, 1'b1, 32'h55);
        push_xf(REG_CW_WIDTH, 1'b1, 32'h2);
        push_xf(REG_NOISE, 1'b1, 32'h4);
        push_xf(REG_CTRL, 1'b1, 32'h1);
        push_xf(REG_DATA_IN, 1'b0, 32'h0);
        seq_q.push_back(1'b0);
        push_rsp(32'h55, 1'b0);
        @(negedge PCLK);
        chk("arb_cmd_ready", 64'(cmd_ready), 64'd0);
        step();
        seq_start = 1'b0;
        seq_run(n, bad);
        chk("seq_psel_cycles", 64'(n), 64'd8);
        chk("seq_busy", 64'(bad), 64'd0);
        chk("seq_done_pulse", 64'(seq_done), 64'd1);
        chk("seq_then_ready", 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 1'b0;
        wait_rsp(lat);

        // Slave error on the second sequence write aborts the rest.
        step();
        err_at = 1;
        nxfer = 0;
        seq_start = 1'b1;
        seq_data_in = 32'h77;
        seq_cw_width = 32'h9;
        push_xf(REG_DATA_IN, 1'b1, 32'h77);
        push_xf(REG_CW_WIDTH, 1'b1, 32'h9);
        seq_q.push_back(1'b1);
        step();
        seq_start = 1'b0;
        seq_run(n, bad);
        chk("abort_psel_cycles", 64'(n), 64'd4);
        chk("abort_done_pulse", 64'(seq_done), 64'd1);
        n = 0;
        repeat (4) begin
            @(negedge PCLK);
            if (PSEL) n++;
        end
        chk("abort_no_more", 64'(n), 64'd0);
        err_at = -1;

        // Reset during ACCESS abandons the transfer.
        step();
        wait_cfg = 10;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_reg = REG_CW_WIDTH;
        cmd_wdata = 32'h0000_FFFF;
        step();
        cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("rst_in_access", 64'({PSEL, PENABLE}), 64'b11);
        PRESETn = 1'b0;
        @(negedge PCLK);
        chk("rst_ctrl", 64'({cmd_ready, rsp_valid, rsp_err, seq_busy,
                             seq_done, PSEL, PENABLE, PWRITE}), 64'd0);
        chk("rst_paddr", 64'(PADDR), 64'd0);
        chk("rst_pwdata", 64'(PWDATA), 64'd0);
        step();
        PRESETn = 1'b1;
        wait_cfg = 0;
        repeat (3) step();

`ifdef ENCDEC_APB_TIMEOUT_EN
        wait_cfg = 1000;
        push_rsp(32'h0, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_reg = REG_DATA_IN;
        step();
        cmd_valid = 1'b0;
        @(negedge PCLK);
        wait_rsp(lat);
        chk("timeout_latency", 64'(lat), 64'(TO + 1));
        @(negedge PCLK);
        chk("timeout_psel", 64'(PSEL), 64'd0);
        wait_cfg = 0;
`endif

        repeat (3) step();
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        chk("seq_q_drained", 64'(seq_q.size()), 64'd0);
        chk("xf_q_drained", 64'(xf_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
